// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART receiver: parity mode
// encodings, the receive FSM state type and a frame-length helper.
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_HIGH = 3'd5
  } rx_state_e;

  // Total bits on the wire for one frame, start bit included.
  function automatic int frame_bits(input int data_bits, input int parity_mode,
                                    input int stop_bits);
    return 1 + data_bits + ((parity_mode != PARITY_NONE) ? 1 : 0) + stop_bits;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Baud counter: free-runs modulo CLKS_PER_BIT, can be forced back to zero
// with restart, and flags the mid-bit point and the last cycle of a bit.
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 521
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic mid_bit,
  output logic full_bit
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] MID_CNT  = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count: restart wins, otherwise wrap at the end of a bit period.
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (restart) begin
      cnt_d = '0;
    end else if (cnt_q == LAST_CNT) begin
      cnt_d = '0;
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign mid_bit  = (cnt_q == MID_CNT);
  assign full_bit = (cnt_q == LAST_CNT);

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 2-flop synchroniser, start-bit glitch filter,
// DATA_BITS data bits LSB first, optional odd/even parity, 1 or 2 stop bits.
// Frame results (word, parity/framing/break flags) are registered together
// and announced by a single-cycle rx_valid strobe.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 521,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 rx_clk,
  input  logic                 rx_rst,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] rx_out,
  output logic                 rx_valid,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_break,
  output logic                 rx_busy
);

  // Handshake: rx_valid is a one-cycle pulse with no back-pressure; rx_out
  // and the three flags are valid in the pulse cycle and hold until the
  // next pulse, so the consumer may sample them at or after rx_valid.

  localparam int IW = $clog2(DATA_BITS);
  localparam logic [IW-1:0] LAST_DATA = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] LAST_STOP = IW'(STOP_BITS - 1);

  // Synchroniser; both stages reset to the idle (high) line level.
  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic rx_s;

  rx_state_e state_q, state_d;

  logic [IW-1:0]        bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_bit_q, par_bit_d;
  logic                 zero_acc_q, zero_acc_d;  // every sample so far was 0
  logic                 ferr_acc_q, ferr_acc_d;  // some stop sample was 0

  logic [DATA_BITS-1:0] out_q, out_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 brk_q, brk_d;
  logic                 valid_q, valid_d;

  logic timer_restart;
  logic mid_bit;
  logic full_bit;
  logic parity_err_c;
  logic busy_c;

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk     (rx_clk),
    .rst     (rx_rst),
    .restart (timer_restart),
    .mid_bit (mid_bit),
    .full_bit(full_bit)
  );

  // Synchroniser next values.
  always_comb begin
    sync1_d = rx_in;
    sync2_d = sync1_q;
  end

  // Synchroniser registers.
  always_ff @(posedge rx_clk or posedge rx_rst) begin
    if (rx_rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign rx_s = sync2_q;

  // FSM state register.
  always_ff @(posedge rx_clk or posedge rx_rst) begin
    if (rx_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic; stop bits end in WAIT_HIGH if the line is still
  // low so a held-low line cannot look like a fresh start bit.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (!rx_s) state_d = START;
      end
      START: begin
        if (mid_bit) state_d = rx_s ? IDLE : DATA;
      end
      DATA: begin
        if (full_bit && (bit_idx_q == LAST_DATA)) begin
          state_d = (PARITY_MODE != PARITY_NONE) ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (full_bit) state_d = STOP;
      end
      STOP: begin
        if (full_bit && (bit_idx_q == LAST_STOP)) begin
          state_d = rx_s ? IDLE : WAIT_HIGH;
        end
      end
      WAIT_HIGH: begin
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: busy covers the validated part of a frame; the timer is
  // held at zero while idle so counting starts with the first low sample,
  // and it is re-aligned on the mid-start decision.
  always_comb begin
    busy_c        = 1'b0;
    timer_restart = 1'b0;
    case (state_q)
      IDLE:      timer_restart = rx_s;
      START:     timer_restart = mid_bit;
      DATA:      busy_c = 1'b1;
      PARITY:    busy_c = 1'b1;
      STOP:      busy_c = 1'b1;
      WAIT_HIGH: timer_restart = 1'b1;
      default:   timer_restart = 1'b1;
    endcase
  end

  // Parity check of the completed word against the received parity bit.
  always_comb begin
    case (PARITY_MODE)
      PARITY_ODD:  parity_err_c = ~(^shift_q ^ par_bit_q);
      PARITY_EVEN: parity_err_c = ^shift_q ^ par_bit_q;
      default:     parity_err_c = 1'b0;
    endcase
  end

  // Datapath: sample bits at mid-bit points, accumulate error/break state,
  // and publish all results together on the last stop sample.
  always_comb begin
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    par_bit_d  = par_bit_q;
    zero_acc_d = zero_acc_q;
    ferr_acc_d = ferr_acc_q;
    out_d      = out_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    brk_d      = brk_q;
    valid_d    = 1'b0;
    case (state_q)
      START: begin
        if (mid_bit && !rx_s) begin
          bit_idx_d  = '0;
          zero_acc_d = 1'b1;
          ferr_acc_d = 1'b0;
        end
      end
      DATA: begin
        if (full_bit) begin
          shift_d[bit_idx_q] = rx_s;
          zero_acc_d         = zero_acc_q & ~rx_s;
          bit_idx_d          = (bit_idx_q == LAST_DATA) ? '0 : bit_idx_q + IW'(1);
        end
      end
      PARITY: begin
        if (full_bit) begin
          par_bit_d  = rx_s;
          zero_acc_d = zero_acc_q & ~rx_s;
        end
      end
      STOP: begin
        if (full_bit) begin
          zero_acc_d = zero_acc_q & ~rx_s;
          ferr_acc_d = ferr_acc_q | ~rx_s;
          bit_idx_d  = bit_idx_q + IW'(1);
          if (bit_idx_q == LAST_STOP) begin
            out_d   = shift_q;
            perr_d  = parity_err_c;
            ferr_d  = ferr_acc_q | ~rx_s;
            brk_d   = zero_acc_q & ~rx_s;
            valid_d = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // Datapath and result registers.
  always_ff @(posedge rx_clk or posedge rx_rst) begin
    if (rx_rst) begin
      bit_idx_q  <= '0;
      shift_q    <= '0;
      par_bit_q  <= 1'b0;
      zero_acc_q <= 1'b0;
      ferr_acc_q <= 1'b0;
      out_q      <= '0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      brk_q      <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      par_bit_q  <= par_bit_d;
      zero_acc_q <= zero_acc_d;
      ferr_acc_q <= ferr_acc_d;
      out_q      <= out_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      brk_q      <= brk_d;
      valid_q    <= valid_d;
    end
  end

  assign rx_out        = out_q;
  assign rx_valid      = valid_q;
  assign rx_parity_err = perr_q;
  assign rx_frame_err  = ferr_q;
  assign rx_break      = brk_q;
  assign rx_busy       = busy_c;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: an 8N1 instance (a) and an 8E1 instance (b) share
// clock and reset. Drivers serialise frames bit by bit and push the expected
// result word and arrival cycle; a negedge monitor pops and compares.
module tb_uart_rx_cfg;
  import uart_pkg::*;

  localparam int C  = 16;
  localparam int H  = (C - 1) / 2;
  localparam int NA = frame_bits(8, PARITY_NONE, 1) - 1;  // bits after start
  localparam int NB = frame_bits(8, PARITY_EVEN, 1) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx_a = 1'b1;
  logic rx_b = 1'b1;

  logic [7:0] out_a, out_b;
  logic valid_a, perr_a, ferr_a, brk_a, busy_a;
  logic valid_b, perr_b, ferr_b, brk_b, busy_b;

  int cyc    = 0;
  int errors = 0;
  int checks = 0;

  // expected word layout: {data[7:0], parity_err, frame_err, break}
  logic [10:0] exp_q_a[$];
  logic [10:0] exp_q_b[$];
  int          exp_cyc_a[$];
  int          exp_cyc_b[$];

  logic        prev_valid_a = 1'b0;
  logic        prev_valid_b = 1'b0;
  logic        glitch_win   = 1'b0;
  logic        busy_seen    = 1'b0;
  logic [10:0] last_a       = '0;

  uart_rx_cfg #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY_MODE(PARITY_NONE),
                .STOP_BITS(1)) dut_a (
    .rx_clk(clk), .rx_rst(rst), .rx_in(rx_a), .rx_out(out_a),
    .rx_valid(valid_a), .rx_parity_err(perr_a), .rx_frame_err(ferr_a),
    .rx_break(brk_a), .rx_busy(busy_a));

  uart_rx_cfg #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY_MODE(PARITY_EVEN),
                .STOP_BITS(1)) dut_b (
    .rx_clk(clk), .rx_rst(rst), .rx_in(rx_b), .rx_out(out_b),
    .rx_valid(valid_b), .rx_parity_err(perr_b), .rx_frame_err(ferr_b),
    .rx_break(brk_b), .rx_busy(busy_b));

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // Reference model: derives flags from the bits placed on the wire.
  function automatic logic [10:0] model(input int sel, input logic [7:0] d,
                                        input logic p, input logic stop);
    logic perr, ferr, brk;
    perr = (sel == 1) ? ((^d) ^ p) : 1'b0;               // even parity
    ferr = ~stop;
    brk  = (d == 8'h00) && ((sel == 0) || !p) && !stop;
    return {d, perr, ferr, brk};
  endfunction

  task automatic check(input string name, input logic [15:0] got,
                       input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic set_line(input int sel, input logic v);
    if (sel == 0) rx_a = v;
    else          rx_b = v;
  endtask

  task automatic wait_bits(input int n);
    repeat (n * C) @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int sel, input logic [10:0] w);
    if (sel == 0) begin
      exp_q_a.push_back(w);
      exp_cyc_a.push_back(cyc + H + NA * C + 3);
    end else begin
      exp_q_b.push_back(w);
      exp_cyc_b.push_back(cyc + H + NB * C + 3);
    end
  endtask

  // Serialise one frame; tail keeps the stop level for extra bit periods.
  task automatic send_frame(input int sel, input logic [7:0] d, input logic p,
                            input logic stop, input int gap, input int tail);
    push_exp(sel, model(sel, d, p, stop));
    set_line(sel, 1'b0);
    wait_bits(1);
    for (int i = 0; i < 8; i++) begin
      set_line(sel, d[i]);
      wait_bits(1);
    end
    if (sel == 1) begin
      set_line(sel, p);
      wait_bits(1);
    end
    set_line(sel, stop);
    wait_bits(1);
    if (tail > 0) begin
      wait_bits(tail);
      check("wait_high_not_busy", {15'd0, (sel == 0) ? busy_a : busy_b}, 16'd0);
    end
    set_line(sel, 1'b1);
    if (gap > 0) wait_bits(gap);
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_q_a.size() != 0 || exp_q_b.size() != 0) && t < 20 * C) begin
      @(posedge clk);
      t++;
    end
    #1;
    check("drain_pending", 16'(exp_q_a.size() + exp_q_b.size()), 16'd0);
  endtask

  task automatic mon(input int sel, input logic v, input logic pv,
                     input logic [10:0] got, input logic busy);
    logic [10:0] e;
    int          ec;
    if (!v) return;
    checks++;
    if ((sel == 0) ? (exp_q_a.size() == 0) : (exp_q_b.size() == 0)) begin
      errors++;
      $display("FAIL unexpected_valid sel=%0d got=%h exp=none cyc=%0d", sel, got, cyc);
    end else begin
      if (sel == 0) begin
        e = exp_q_a.pop_front(); ec = exp_cyc_a.pop_front(); last_a = e;
      end else begin
        e = exp_q_b.pop_front(); ec = exp_cyc_b.pop_front();
      end
      if (got !== e || cyc != ec) begin
        errors++;
        $display("FAIL frame sel=%0d got=%h exp=%h cyc=%0d exp_cyc=%0d",
                 sel, got, e, cyc, ec);
      end
    end
    checks++;
    if (busy !== 1'b0 || pv !== 1'b0) begin
      errors++;
      $display("FAIL pulse_shape sel=%0d busy=%b prev_valid=%b exp=0,0", sel, busy, pv);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (!rst) begin
      mon(0, valid_a, prev_valid_a, {out_a, perr_a, ferr_a, brk_a}, busy_a);
      mon(1, valid_b, prev_valid_b, {out_b, perr_b, ferr_b, brk_b}, busy_b);
      prev_valid_a = valid_a;
      prev_valid_b = valid_b;
      if (glitch_win && busy_a) busy_seen = 1'b1;
    end
  end

  initial begin
    // reset
    repeat (3) @(posedge clk);
    #1;
    check("reset_a", {3'd0, out_a, perr_a, ferr_a, brk_a, busy_a, valid_a}, 16'd0);
    check("reset_b", {3'd0, out_b, perr_b, ferr_b, brk_b, busy_b, valid_b}, 16'd0);
    rst = 1'b0;
    wait_bits(1);

    // back-to-back 8N1
    send_frame(0, 8'hE3, 1'b0, 1'b1, 0, 0);
    send_frame(0, 8'h1C, 1'b0, 1'b1, 2, 0);
    drain();

    // 8E1 good and bad parity
    send_frame(1, 8'hA5, 1'b0, 1'b1, 1, 0);
    send_frame(1, 8'hA5, 1'b1, 1'b1, 1, 0);
    drain();

    // framing error, line held low afterwards
    send_frame(0, 8'h55, 1'b0, 1'b0, 2, 3);
    drain();

    // start-bit glitch
    glitch_win = 1'b1;
    busy_seen  = 1'b0;
    set_line(0, 1'b0);
    repeat (C / 4) @(posedge clk);
    #1;
    set_line(0, 1'b1);
    wait_bits(2);
    glitch_win = 1'b0;
    check("glitch_busy", {15'd0, busy_seen}, 16'd0);
    check("glitch_hold", {5'd0, out_a, perr_a, ferr_a, brk_a}, {5'd0, last_a});

    // break: line low for 20 bit periods
    push_exp(0, model(0, 8'h00, 1'b0, 1'b0));
    set_line(0, 1'b0);
    wait_bits(20);
    set_line(0, 1'b1);
    wait_bits(2);
    send_frame(0, 8'h3C, 1'b0, 1'b1, 2, 0);
    drain();

    // reset mid-frame after four data bits of 0xFF
    set_line(0, 1'b0);
    wait_bits(1);
    set_line(0, 1'b1);
    wait_bits(4);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("midreset_a", {3'd0, out_a, perr_a, ferr_a, brk_a, busy_a, valid_a}, 16'd0);
    check("midreset_b", {3'd0, out_b, perr_b, ferr_b, brk_b, busy_b, valid_b}, 16'd0);
    rst = 1'b0;
    wait_bits(2);
    send_frame(0, 8'h81, 1'b0, 1'b1, 2, 0);
    drain();

    // randomized frames on both receivers
    for (int n = 0; n < 24; n++) begin
      int          sel;
      logic [7:0]  d;
      logic        p, stop;
      int          gap;
      sel  = $urandom_range(0, 1);
      d    = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 5) == 0) d = 8'h00;
      p    = ($urandom_range(0, 2) == 0) ? ~(^d) : (^d);
      stop = ($urandom_range(0, 5) != 0);
      gap  = stop ? $urandom_range(0, 2) : $urandom_range(1, 2);
      send_frame(sel, d, p, stop, gap, 0);
    end
    wait_bits(2);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_cfg.md
Name: uart_rx_cfg

Overview:
Parametrised UART receiver; successor to the fixed 8N1 receiver.
- Data width, parity mode and stop-bit count are configurable.
- Adds a per-frame valid strobe, parity/framing error flags, break detection and start-bit glitch rejection.
- Sits between the async serial pin and the byte-consumer logic, in the rx_clk domain.

Parameters:
- CLKS_PER_BIT, 521, rx_clk cycles per bit (clock freq / baud); must be >= 4.
- DATA_BITS, 8, data bits per frame; legal range 5..9.
- PARITY_MODE, 0, 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1, 1 or 2.

Ports:
- rx_clk  in  1  sole clock.
- rx_rst  in  1  asynchronous, active-high reset.
- rx_in  in  1  asynchronous serial line; idle high.
- rx_out  out  DATA_BITS  last received word, LSB received first.
- rx_valid  out  1  one-cycle pulse at end of each frame.
- rx_parity_err  out  1  parity mismatch on the frame that last pulsed rx_valid.
- rx_frame_err  out  1  a stop bit was sampled low on that frame.
- rx_break  out  1  break condition on that frame.
- rx_busy  out  1  high from validated start bit until the state machine returns to IDLE.

Behaviour:
- Reset values: rx_out = 0, all flags = 0, rx_busy = 0, FSM = IDLE, synchroniser flops = 1.
- rx_in passes through a 2-flop synchroniser; all logic uses its output (rx_s).
- Bit counter width is $clog2(CLKS_PER_BIT); a separate bit index counts data bits.
- FSM states and transitions:
  - IDLE: rx_s = 0 -> START, clear counter.
  - START: count to (CLKS_PER_BIT-1)/2 (mid start bit). If rx_s still 0 -> DATA, rx_busy = 1. Else glitch: back to IDLE, no outputs.
  - DATA: every CLKS_PER_BIT cycles sample rx_s into shift register position = bit index, LSB first. After DATA_BITS samples -> PARITY if PARITY_MODE != 0, else STOP.
  - PARITY: after CLKS_PER_BIT cycles sample the parity bit.
    - Odd mode: error if XOR(data, parity) = 0.
    - Even mode: error if XOR(data, parity) = 1.
  - STOP: sample each stop bit at its mid-point. Any low sample sets the framing error. After the last stop sample:
    - register rx_out and all flags;
    - pulse rx_valid for exactly one cycle, on the cycle after that sample;
    - go to IDLE if rx_s = 1, else WAIT_HIGH.
  - WAIT_HIGH: stay until rx_s = 1, then IDLE. This stops a held-low line from retriggering.
- rx_busy drops in the same cycle rx_valid pulses (WAIT_HIGH counts as not busy).
- Latency: rx_valid rises 2 + (CLKS_PER_BIT-1)/2 + CLKS_PER_BIT × (DATA_BITS + P + STOP_BITS) + 1 cycles after rx_in falls. P = 1 if parity is enabled, else 0.
- rx_out and all flags hold their values between frames. They update only together with rx_valid, so they are valid at, and stable after, the pulse.
- Break flag: set when all data bits, the parity bit (if any) and every stop bit are 0. rx_frame_err is always also 1 in that case.
- When parity is disabled, rx_parity_err is always 0.
- Back-to-back frames: a start edge seen in IDLE on the cycle after the stop-bit mid-point is accepted. No dead time beyond the half stop bit.
- rx_rst asserted mid-frame: immediate return to reset values, partial frame discarded, no rx_valid.

Decomposition:
- Package uart_pkg holds:
  - PARITY_NONE / PARITY_ODD / PARITY_EVEN constants;
  - the FSM state enum (IDLE, START, DATA, PARITY, STOP, WAIT_HIGH);
  - a function returning the frame length in bits.
- Natural sub-module: uart_bit_timer. It is the baud counter with a restart input, a mid-bit output and a full-bit tick.
- The synchroniser stays inline.

Test Plan:
Bit period is CLKS_PER_BIT clocks in every scenario.
1. 8N1: send 0xE3, then 0x1C back-to-back -> two rx_valid pulses exactly 10 bit periods apart; rx_out = E3 then 1C; all flags 0.
2. 8E1: send 0xA5 with parity 0 -> rx_parity_err = 0. Resend with parity 1 -> rx_valid pulses, rx_out = A5, rx_parity_err = 1.
3. 8N1: send 0x55 with stop bit 0 -> rx_valid, rx_out = 55, rx_frame_err = 1, rx_break = 0. FSM stays in WAIT_HIGH until the line returns high.
4. Low glitch of CLKS_PER_BIT/4 cycles -> no rx_valid, rx_busy never asserts or returns to 0. Outputs unchanged.
5. Line held low for 20 bit periods -> exactly one rx_valid with rx_out = 00, rx_break = 1, rx_frame_err = 1. Release, then send 0x3C -> received correctly, flags 0.
6. Assert rx_rst after 4 data bits of 0xFF -> no rx_valid, outputs at reset values. Then send 0x81 -> rx_out = 81.
